// File: rtl/tsu0_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package tsu0_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_DONE
  } arb_state_t;

  localparam int PORT_CPU  = 0;
  localparam int PORT_DBG  = 1;
  localparam int BURST_MAX = 16;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin select: a lone requester wins, a tie goes to the port
// that did not win last time.
module rr_pick2
  import tsu0_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win = req;
    if (req[PORT_CPU] && req[PORT_DBG])
      win = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between the CPU and debug ports with a req/ack
// handshake, round-robin fairness and capped locked bursts.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ARB_IDLE  | no owner; arbitrate among pending requests
//   ARB_ISSUE | address/data on the RAM pins, mem_write high for writes
//   ARB_WAIT  | counting down the RAM read latency
//   ARB_DONE  | ack pulse to owner; continue a locked burst or release
module mem_arbiter
  import tsu0_pkg::*;
#(
  parameter int ADDR_SIZE = 12,
  parameter int WORD_SIZE = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic [1:0]           req,
  input  logic [1:0]           lock,
  input  logic [1:0]           we,
  input  logic [ADDR_SIZE-1:0] addr0,
  input  logic [ADDR_SIZE-1:0] addr1,
  input  logic [WORD_SIZE-1:0] wdata0,
  input  logic [WORD_SIZE-1:0] wdata1,
  output logic [1:0]           ack,
  output logic [WORD_SIZE-1:0] rdata,
  output logic [1:0]           gnt,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_in,
  output logic                 mem_write,
  input  logic [WORD_SIZE-1:0] mem_out
);

  arb_state_t state, state_nxt;
  logic       last;
  logic       lock_q;
  logic       is_wr;
  logic [1:0] lat_cnt;
  logic [3:0] burst_left;
  logic [1:0] win;
  logic       port;
  logic       load;
  logic       grant;
  logic       drop_gnt;
  logic       capture;

  rr_pick2 u_pick (
    .req  (req),
    .last (last),
    .win  (win)
  );

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    load      = 1'b0;
    drop_gnt  = 1'b0;
    capture   = 1'b0;
    port      = gnt[PORT_DBG];
    case (state)
      ARB_IDLE: begin
        if (|req) begin
          state_nxt = ARB_ISSUE;
          grant     = 1'b1;
          load      = 1'b1;
          port      = win[PORT_DBG];
        end
      end
      ARB_ISSUE: state_nxt = is_wr ? ARB_DONE : ARB_WAIT;
      ARB_WAIT: begin
        if (lat_cnt == 2'd0) begin
          state_nxt = ARB_DONE;
          capture   = 1'b1;
        end
      end
      ARB_DONE: begin
        // The requester presents its next beat during the ack cycle.
        if (lock_q && req[port] && burst_left != 4'd0) begin
          state_nxt = ARB_ISSUE;
          load      = 1'b1;
        end else begin
          state_nxt = ARB_IDLE;
          drop_gnt  = 1'b1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      last       <= 1'b1;
      gnt        <= '0;
      ack        <= '0;
      rdata      <= '0;
      mem_addr   <= '0;
      mem_in     <= '0;
      mem_write  <= 1'b0;
      lock_q     <= 1'b0;
      is_wr      <= 1'b0;
      lat_cnt    <= '0;
      burst_left <= '0;
    end else begin
      state     <= state_nxt;
      ack       <= (state_nxt == ARB_DONE) ? gnt : 2'b00;
      mem_write <= load & we[port];
      if (load) begin
        mem_addr <= port ? addr1 : addr0;
        mem_in   <= port ? wdata1 : wdata0;
        is_wr    <= we[port];
        lock_q   <= lock[port];
      end
      if (grant) begin
        gnt        <= win;
        last       <= win[PORT_DBG];
        burst_left <= 4'(BURST_MAX - 1);
      end else if (load) begin
        burst_left <= burst_left - 4'd1;
      end
      if (drop_gnt)
        gnt <= '0;
      if (state == ARB_ISSUE)
        lat_cnt <= 2'(RD_LAT - 1);
      else if (state == ARB_WAIT)
        lat_cnt <= lat_cnt - 2'd1;
      if (capture)
        rdata <= mem_out;
    end
  end

endmodule
